// File: rtl/control_sequencer.sv
// control_sequencer: hardwired FSM that drives the datapath control strobes.
// It runs instruction fetch (T0-T2) and execute (T3-T6) for register-format
// ALU, MUL/DIV, NOP and HALT instructions. It also provides a memory-ready
// stall on fetch and a run/halt interface.
//
// Optional feature: define SEQ_MULDIV_EN to build the MUL/DIV sequence
// (T5 LO load, T6 HI load). When it is undefined, ops 01111/10000 decode as
// illegal, and T6, LOin and HIin are never asserted.
//
// Ports:
//   Clock, Reset      rising-edge clock, async active-high reset
//   run               level; start/continue execution, leave HALT on re-rise
//   mem_ready         fetch data valid during T1
//   ir[31:0]          datapath IR (op/Ra/Rb/Rc fields), valid from T3
//   PCout..HIin       datapath strobes (Moore, decoded from state)
//   r_out, r_in       one-hot register drive / load selects
//   operation[4:0]    ALU opcode, loaded in T4 and held until the next T4
//   halted            high while in HALT
//   illegal           one-cycle pulse in T3 for an undefined opcode
//   mem_timeout       sticky flag: T1 wait reached MEM_WAIT_MAX
module control_sequencer #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        run,
  input  logic        mem_ready,
  input  logic [31:0] ir,
  output logic        PCout,
  output logic        MARin,
  output logic        IncPC,
  output logic        Zin,
  output logic        PCin,
  output logic        Read,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zlowout,
  output logic        ZHighout,
  output logic        LOin,
  output logic        HIin,
  output logic [15:0] r_out,
  output logic [15:0] r_in,
  output logic [4:0]  operation,
  output logic        halted,
  output logic        illegal,
  output logic        mem_timeout
);

  localparam int CW = (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_WAIT_MAX - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
  } state_t;

  state_t        r_state, w_next;
  logic [CW-1:0] r_wait;
  logic          r_timeout;
  logic          r_run_low;   // run seen low while halted; next high restarts
  logic [4:0]    r_op;

  logic [4:0] w_op;
  logic [3:0] w_ra, w_rb, w_rc;
  logic       w_alu, w_md, w_nop, w_halt;
  logic       w_unused_ir;

  assign w_op  = ir[31:27];
  assign w_ra  = ir[26:23];
  assign w_rb  = ir[22:19];
  assign w_rc  = ir[18:15];
  assign w_unused_ir = ^ir[14:0];

  assign w_alu  = (w_op <= 5'b01110);
`ifdef SEQ_MULDIV_EN
  assign w_md   = (w_op == 5'b01111) || (w_op == 5'b10000);
`else
  assign w_md   = 1'b0;
`endif
  assign w_nop  = (w_op == 5'b11010);
  assign w_halt = (w_op == 5'b11011);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_wait    <= '0;
      r_timeout <= 1'b0;
      r_run_low <= 1'b0;
      r_op      <= 5'b0;
    end else begin
      r_state <= w_next;
      // The counter only advances on stalled T1 cycles; anything else clears it.
      if (r_state == S_T1 && !mem_ready) begin
        r_wait <= r_wait + CW'(1);
        if (r_wait == WAIT_LAST) r_timeout <= 1'b1;
      end else begin
        r_wait <= '0;
      end
      if (r_state == S_HALT) begin
        if (!run) r_run_low <= 1'b1;
      end else begin
        r_run_low <= 1'b0;
      end
      if (w_next == S_T4) r_op <= w_op;
    end
  end

  always_comb begin
    w_next   = r_state;
    PCout    = 1'b0;
    MARin    = 1'b0;
    IncPC    = 1'b0;
    Zin      = 1'b0;
    PCin     = 1'b0;
    Read     = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zlowout  = 1'b0;
    ZHighout = 1'b0;
    LOin     = 1'b0;
    HIin     = 1'b0;
    r_out    = 16'h0;
    r_in     = 16'h0;
    halted   = 1'b0;
    illegal  = 1'b0;
    case (r_state)
      S_IDLE: if (run) w_next = S_T0;
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
        w_next = S_T1;
      end
      S_T1: begin
        Zlowout = 1'b1; Read = 1'b1; MDRin = 1'b1;
        PCin    = (r_wait == '0);   // load the incremented PC only once
        if (mem_ready)                w_next = S_T2;
        else if (r_wait == WAIT_LAST) w_next = S_IDLE;
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        w_next = S_T3;
      end
      S_T3: begin
        if (w_alu) begin
          r_out = 16'h1 << w_rb; Yin = 1'b1; w_next = S_T4;
        end else if (w_md) begin
          r_out = 16'h1 << w_ra; Yin = 1'b1; w_next = S_T4;
        end else if (w_halt) begin
          w_next = S_HALT;
        end else begin
          illegal = !w_nop;
          w_next  = S_T0;
        end
      end
      S_T4: begin
        r_out  = 16'h1 << (w_md ? w_rb : w_rc);
        Zin    = 1'b1;
        w_next = S_T5;
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (w_md) begin
          LOin   = 1'b1;
          w_next = S_T6;
        end else begin
          r_in   = 16'h1 << w_ra;
          w_next = run ? S_T0 : S_IDLE;
        end
      end
`ifdef SEQ_MULDIV_EN
      S_T6: begin
        ZHighout = 1'b1; HIin = 1'b1;
        w_next   = run ? S_T0 : S_IDLE;
      end
`endif
      S_HALT: begin
        halted = 1'b1;
        if (r_run_low && run) w_next = S_T0;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign operation   = r_op;
  assign mem_timeout = r_timeout;

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit that sits directly upstream of `datapath` and drives its control strobes. It replaces hand-sequenced bench stimulus with an FSM that runs instruction fetch (T0–T2) and execute (T3–T6) for register-format ALU, MUL/DIV, NOP and HALT instructions. Decode uses the IR contents returned from the datapath. It also provides a memory-ready handshake on fetch and a run/halt interface.

## Interface

**Parameters**
- `MEM_WAIT_MAX`, default 15: maximum T1 wait cycles before `mem_timeout` is asserted.

**Ports**
- `Clock` in 1: sole clock; all state changes on rising edge.
- `Reset` in 1: asynchronous, active-high; forces IDLE and clears all outputs.
- `run` in 1: level; leaves IDLE/HALT when high.
- `mem_ready` in 1: memory data valid on `Mdatain` during T1.
- `ir` in 32: `datapath` IR contents; valid from T3.
- `PCout`, `MARin`, `IncPC`, `Zin`, `PCin`, `Read`, `MDRin`, `MDRout`, `IRin`, `Yin`, `Zlowout`, `ZHighout`, `LOin`, `HIin` out 1 each: datapath strobes.
- `r_out` out 16: one-hot register bus-drive select (R0–R15).
- `r_in` out 16: one-hot register load select.
- `operation` out 5: ALU opcode to the datapath.
- `halted` out 1: high in HALT.
- `illegal` out 1: one-cycle pulse on undefined opcode.
- `mem_timeout` out 1: sticky until Reset; T1 wait exceeded.

## Operation

- Instruction fields: op = `ir[31:27]`, Ra = `ir[26:23]`, Rb = `ir[22:19]`, Rc = `ir[18:15]`.
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALT. Moore outputs are decoded from the state register. `r_out`/`r_in` are decoded from the IR fields.
- **IDLE:** all strobes 0. Go to T0 when `run`=1.
- **T0:** `PCout`, `MARin`, `IncPC`, `Zin`.
- **T1:** `Zlowout`, `PCin`, `Read`, `MDRin`.
  - Stay in T1 while `mem_ready`=0. `PCin` is asserted only in the first T1 cycle.
  - Go to T2 when `mem_ready`=1.
  - A wait counter increments each stalled cycle. When it reaches `MEM_WAIT_MAX`, set `mem_timeout` and go to IDLE.
- **T2:** `MDRout`, `IRin`.
- **T3, by op:**
  - op ≤ 5'b01110 (3-register ALU): `r_out`=1<<Rb, `Yin`.
  - op 5'b01111 MUL / 5'b10000 DIV: `r_out`=1<<Ra, `Yin`.
  - op 5'b11010 NOP: no strobes; next state T0.
  - op 5'b11011 HALT: no strobes; next state HALT.
  - Any other op: pulse `illegal`; next state T0.
- **T4:**
  - ALU: `r_out`=1<<Rc, `Zin`, `operation`=op.
  - MUL/DIV: `r_out`=1<<Rb, `Zin`, `operation`=op.
- **T5:**
  - ALU: `Zlowout`, `r_in`=1<<Ra; then T0 if `run`, else IDLE.
  - MUL/DIV: `Zlowout`, `LOin`.
- **T6 (MUL/DIV only):** `ZHighout`, `HIin`; then T0 if `run`, else IDLE.
- **HALT:** `halted`=1. Leave only via Reset, or when `run` falls then rises; on that rising edge go to T0.
- **Invariants:**
  - At most one bus driver per cycle among `PCout`, `MDRout`, `Zlowout`, `ZHighout` and `r_out` bits.
  - `r_in` and `r_out` are each at most one-hot.
- `operation` holds its last value outside T4 and is 0 after Reset.

## Timing

- Reset (asynchronous): state IDLE, wait counter 0.
  - All strobes, `r_out`, `r_in`, `operation`, `halted`, `illegal` and `mem_timeout` are 0.
- Reset asserted mid-instruction aborts immediately; no further strobes are asserted.
- Latency with zero memory wait:
  - ALU: 6 cycles, T0–T5.
  - MUL/DIV: 7 cycles, T0–T6.
  - NOP and illegal: 4 cycles.
- Each cycle of `mem_ready`=0 in T1 adds one cycle.
- `mem_ready` is sampled at the T1 rising edge. `mem_ready`=1 on the first T1 cycle means no stall.
- `run` is sampled only at IDLE exit, end of T5/T6, and in HALT. Dropping `run` mid-instruction completes the current instruction.

## Configuration

- Macro: `SEQ_MULDIV_EN`.
  - Defined: MUL/DIV sequences (T5 LO, T6 HI) are built.
  - Undefined: ops 5'b01111 and 5'b10000 decode as illegal; state T6, `LOin` and `HIin` are tied to 0.

## Test plan

- AND R4,R3,R7: `ir`=0x2A1B8000, `mem_ready`=1, `run`=1 → T3 `r_out`=0x0008 with `Yin`; T4 `r_out`=0x0080 with `Zin` and `operation`=5'b00101; T5 `r_in`=0x0010 with `Zlowout`; next cycle T0.
- Memory stall: `mem_ready` low for 3 T1 cycles → T1 lasts 4 cycles, `PCin` high only in the first, `Read` held for all 4; instruction completes in 9 cycles.
- MUL R2,R6 (`SEQ_MULDIV_EN` defined): `ir`=0x79300000 → T3 `r_out`=0x0004; T4 `r_out`=0x0040; T5 `LOin`; T6 `HIin` with `ZHighout`. With the macro undefined: `illegal` pulses in T3, then T0.
- HALT: `ir`=0xD8000000 → `halted`=1 and strobes 0 for 20 cycles with `run`=1; `run` 1→0→1 → T0.
- Illegal and timeout:
  - `ir`=0xF8000000 → one-cycle `illegal` pulse, no `r_in` activity.
  - `mem_ready`=0 for 15 stalled cycles → `mem_timeout`=1, state IDLE.
- Reset mid-T4 → all outputs 0 in the same cycle; after release, IDLE, then T0 with `run`=1.
